// File: rtl/seq_pkg.sv
// Shared types and constants for the fetch/execute sequencer of the 8-bit CPU.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_F0   = 3'd2,
    ST_F1   = 3'd3,
    ST_F2   = 3'd4,
    ST_F3   = 3'd5,
    ST_EXEC = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  localparam logic [2:0] CLS_NOP  = 3'b000;
  localparam logic [2:0] CLS_ALU  = 3'b001;
  localparam logic [2:0] CLS_JMP  = 3'b010;
  localparam logic [2:0] CLS_JZ   = 3'b011;
  localparam logic [2:0] CLS_HALT = 3'b111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int INSTR_BYTES = 3;

endpackage

// File: rtl/seq_ram_mux.sv
// Combinational RAM port mux: the loader drives the RAM only while it holds the grant.
module seq_ram_mux
  import seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              loader_sel,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  // Select RAM port owner.
  always_comb begin
    ram_addr  = fetch_addr;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (loader_sel) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_data;
      ram_we    = ld_we;
    end else begin
      ram_addr  = fetch_addr;
      ram_wdata = '0;
      ram_we    = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/execute controller: fetches 3-byte instructions, drives datapath
// strobes and arbitrates the single-port RAM with an external program loader.
module fetch_exec_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0,
  parameter int ZF_BIT   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_req,
  output logic              ld_gnt,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] alu_flags,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] alu_op,
  output logic              reg_load_a,
  output logic              reg_load_b,
  output logic              reg_load_c,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  state_e            state_q, state_d, ret_q, ret_d;
  logic [ADDR_W-1:0] pc_q, pc_d, fetch_addr_s;
  logic [DATA_W-1:0] ir_q, ir_d, op1_q, op1_d, op2_q, op2_d, alu_op_q, alu_op_d;
  logic              load_a_q, load_a_d, load_b_q, load_b_d, load_c_q, load_c_d;
  logic              gnt_q, gnt_d, busy_q, busy_d, halted_q, halted_d;
  logic [2:0]        cls_s;
  logic              unused_flags_s;

  assign cls_s          = ir_q[7:5];
  assign unused_flags_s = ^alu_flags;

  // Next-state, fetch address, decode and registered-output precompute.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    alu_op_d     = alu_op_q;
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;
    load_c_d     = 1'b0;
    fetch_addr_s = pc_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (ld_req) begin
          state_d = ST_LOAD;
          ret_d   = state_q;
        end else if (start) begin
          pc_d    = RST_PC;
          state_d = ST_F0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (!ld_req) begin
          state_d = ret_q;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_F0: begin
        fetch_addr_s = pc_q;
        state_d      = ST_F1;
      end
      ST_F1: begin
        fetch_addr_s = pc_q + ADDR_W'(1);
        ir_d         = ram_rdata;
        state_d      = ST_F2;
      end
      ST_F2: begin
        fetch_addr_s = pc_q + ADDR_W'(2);
        op1_d        = ram_rdata;
        state_d      = ST_F3;
      end
      ST_F3: begin
        // Strobes are registered on EXEC entry so they are high exactly during EXEC.
        op2_d   = ram_rdata;
        state_d = ST_EXEC;
        if (cls_s == CLS_ALU) begin
          alu_op_d = ir_q;
          case (ir_q[1:0])
            SEL_A:   load_a_d = 1'b1;
            SEL_B:   load_b_d = 1'b1;
            SEL_C:   load_c_d = 1'b1;
            default: load_a_d = 1'b0;
          endcase
        end else begin
          alu_op_d = alu_op_q;
        end
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_JMP:  pc_d = op1_q[ADDR_W-1:0];
          CLS_JZ:   pc_d = alu_flags[ZF_BIT] ? op1_q[ADDR_W-1:0] : pc_q + PC_STEP;
          CLS_HALT: pc_d = pc_q;
          default:  pc_d = pc_q + PC_STEP;
        endcase
        state_d = (cls_s == CLS_HALT) ? ST_HALT : ST_F0;
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_d    = (state_d == ST_LOAD);
    busy_d   = (state_d inside {ST_F0, ST_F1, ST_F2, ST_F3, ST_EXEC});
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      pc_q     <= RST_PC;
      ir_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      alu_op_q <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      load_c_q <= 1'b0;
      gnt_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      alu_op_q <= alu_op_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      load_c_q <= load_c_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  seq_ram_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram_mux (
    .loader_sel (gnt_q),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .fetch_addr (fetch_addr_s),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we)
  );

  assign ld_gnt     = gnt_q;
  assign ir         = ir_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign alu_op     = alu_op_q;
  assign reg_load_a = load_a_q;
  assign reg_load_b = load_b_q;
  assign reg_load_c = load_c_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed self-checking bench for fetch_exec_sequencer with a behavioural 64x8 sync RAM.
module tb_fetch_exec_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, ld_req, ld_gnt, ld_we, ram_we;
  logic [5:0] ld_addr, ram_addr, pc;
  logic [7:0] ld_data, ram_wdata, ram_rdata, alu_flags;
  logic [7:0] ir, op1, op2, alu_op;
  logic       reg_load_a, reg_load_b, reg_load_c, busy, halted;
  logic [7:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // RAM model: synchronous read, one-cycle latency.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  fetch_exec_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .ld_req(ld_req), .ld_gnt(ld_gnt),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .alu_flags(alu_flags),
    .ir(ir), .op1(op1), .op2(op2), .alu_op(alu_op), .reg_load_a(reg_load_a),
    .reg_load_b(reg_load_b), .reg_load_c(reg_load_c), .pc(pc), .busy(busy), .halted(halted)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; start = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = 6'd0; ld_data = 8'd0; alu_flags = 8'd0;
    tick;
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic load_bytes(input logic [5:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2);
    ld_req = 1'b1;
    tick;
    ld_we = 1'b1; ld_addr = a;          ld_data = d0; tick;
    ld_addr = a + 6'd1; ld_data = d1; tick;
    ld_addr = a + 6'd2; ld_data = d2; tick;
    ld_we = 1'b0; ld_req = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    load_bytes(6'd0, 8'h21, 8'h00, 8'h00);
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    checks++; if (ir !== 8'h21) begin errors++; $display("FAIL rst_pre_ir got %h exp 21", ir); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (ir !== 8'h00) begin errors++; $display("FAIL rst_ir got %h exp 00", ir); end
    checks++; if (pc !== 6'd0) begin errors++; $display("FAIL rst_pc got %0d exp 0", pc); end
    checks++; if ({busy, halted, ld_gnt, ram_we, reg_load_a, reg_load_b, reg_load_c} !== 7'd0) begin
      errors++; $display("FAIL rst_flags got %b exp 0000000",
                         {busy, halted, ld_gnt, ram_we, reg_load_a, reg_load_b, reg_load_c});
    end
    checks++; if ({alu_op, op1, op2} !== 24'd0) begin
      errors++; $display("FAIL rst_regs got %h exp 000000", {alu_op, op1, op2});
    end
    tick;
    reset = 1'b1;
    tick; tick; tick;
    checks++; if ({busy, halted, ld_gnt} !== 3'b000) begin
      errors++; $display("FAIL idle_stay got %b exp 000", {busy, halted, ld_gnt});
    end
  endtask

  task automatic test_load_run;
    ld_req = 1'b1;
    tick;
    checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt got %b exp 1", ld_gnt); end
    for (int i = 0; i < 6; i++) begin
      ld_we = 1'b1; ld_addr = 6'(i);
      ld_data = (i == 0) ? 8'h21 : (i == 3) ? 8'hE0 : 8'h00;
      #1;
      checks++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ld_addr, ld_data}) begin
        errors++; $display("FAIL load_port got %b/%0d/%h exp 1/%0d/%h", ram_we, ram_addr, ram_wdata,
                           ld_addr, ld_data);
      end
      tick;
    end
    ld_we = 1'b0; ld_req = 1'b0;
    tick;
    checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL load_drop got %b exp 0", ld_gnt); end
    checks++; if ({mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} !== 48'h210000E00000) begin
      errors++; $display("FAIL load_mem got %h%h%h%h%h%h exp 210000e00000",
                         mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]);
    end
    start = 1'b1; tick; start = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      checks++; if ({reg_load_a, reg_load_b, reg_load_c} !== {1'b0, (n == 5), 1'b0}) begin
        errors++; $display("FAIL run_strobe cyc %0d got %b exp 0%0d0", n,
                           {reg_load_a, reg_load_b, reg_load_c}, (n == 5));
      end
      if (n == 5) begin
        checks++; if (alu_op !== 8'h21) begin errors++; $display("FAIL run_aluop got %h exp 21", alu_op); end
      end
      if (n == 6) begin
        checks++; if (pc !== 6'd3) begin errors++; $display("FAIL run_pc3 got %0d exp 3", pc); end
      end
      if (n < 11) tick;
    end
    checks++; if ({halted, busy} !== 2'b10) begin
      errors++; $display("FAIL halt_state got %b exp 10", {halted, busy});
    end
    checks++; if (pc !== 6'd3) begin errors++; $display("FAIL halt_pc got %0d exp 3", pc); end
    checks++; if (alu_op !== 8'h21) begin errors++; $display("FAIL aluop_hold got %h exp 21", alu_op); end
  endtask

  task automatic test_jump_wrap;
    do_reset;
    load_bytes(6'd62, 8'h00, 8'h00, 8'h00);
    load_bytes(6'd0, 8'h40, 8'h3E, 8'h00);
    start = 1'b1; tick; start = 1'b0;
    checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL jmp_f0 got %0d exp 0", ram_addr); end
    for (int n = 2; n <= 6; n++) tick;
    checks++; if (pc !== 6'd62) begin errors++; $display("FAIL jmp_pc got %0d exp 62", pc); end
    checks++; if (ram_addr !== 6'd62) begin errors++; $display("FAIL wrap_a0 got %0d exp 62", ram_addr); end
    tick;
    checks++; if (ram_addr !== 6'd63) begin errors++; $display("FAIL wrap_a1 got %0d exp 63", ram_addr); end
    tick;
    checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL wrap_a2 got %0d exp 0", ram_addr); end
    tick; tick; tick;
    checks++; if (pc !== 6'd1) begin errors++; $display("FAIL wrap_pc got %0d exp 1", pc); end
  endtask

  task automatic test_jz;
    for (int k = 0; k < 2; k++) begin
      do_reset;
      load_bytes(6'd0, 8'h60, 8'h10, 8'h00);
      alu_flags = (k == 0) ? 8'h01 : 8'hFE;
      start = 1'b1; tick; start = 1'b0;
      for (int n = 2; n <= 6; n++) tick;
      checks++; if (pc !== ((k == 0) ? 6'h10 : 6'd3)) begin
        errors++; $display("FAIL jz_pc flag %0d got %0d exp %0d", 1 - k, pc, (k == 0) ? 16 : 3);
      end
    end
  endtask

  task automatic test_arbitration;
    do_reset;
    load_bytes(6'd0, 8'hE0, 8'h00, 8'h00);
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 6'd9; ld_data = 8'hAA;
    for (int n = 4; n <= 6; n++) begin
      tick;
      checks++; if ({ld_gnt, ram_we} !== 2'b00) begin
        errors++; $display("FAIL arb_hold cyc %0d got %b exp 00", n, {ld_gnt, ram_we});
      end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL arb_halt got %b exp 1", halted); end
    ld_we = 1'b0;
    tick;
    checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL arb_gnt got %b exp 1", ld_gnt); end
    ld_req = 1'b0;
    tick;
    checks++; if ({ld_gnt, halted} !== 2'b01) begin
      errors++; $display("FAIL arb_ret got %b exp 01", {ld_gnt, halted});
    end
    do_reset;
    start = 1'b1; ld_req = 1'b1;
    tick;
    start = 1'b0;
    checks++; if ({ld_gnt, busy} !== 2'b10) begin
      errors++; $display("FAIL arb_tie got %b exp 10", {ld_gnt, busy});
    end
    ld_req = 1'b0;
    tick;
    checks++; if ({ld_gnt, busy, halted} !== 3'b000) begin
      errors++; $display("FAIL arb_tie_ret got %b exp 000", {ld_gnt, busy, halted});
    end
  endtask

  task automatic test_reset_in_load;
    do_reset;
    load_bytes(6'd7, 8'h00, 8'h00, 8'h00);
    ld_req = 1'b1;
    tick;
    ld_we = 1'b1; ld_addr = 6'd7; ld_data = 8'h55;
    #1;
    checks++; if ({ld_gnt, ram_we} !== 2'b11) begin
      errors++; $display("FAIL rl_pre got %b exp 11", {ld_gnt, ram_we});
    end
    reset = 1'b0;
    #1;
    checks++; if ({ld_gnt, ram_we} !== 2'b00) begin
      errors++; $display("FAIL rl_async got %b exp 00", {ld_gnt, ram_we});
    end
    tick;
    checks++; if (mem[7] !== 8'h00) begin errors++; $display("FAIL rl_nowrite got %h exp 00", mem[7]); end
    ld_req = 1'b0; ld_we = 1'b0;
    reset = 1'b1;
    tick;
    checks++; if ({ld_gnt, busy, halted} !== 3'b000) begin
      errors++; $display("FAIL rl_idle got %b exp 000", {ld_gnt, busy, halted});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = 6'd0; ld_data = 8'd0; alu_flags = 8'd0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    test_reset;
    test_load_run;
    test_jump_wrap;
    test_jz;
    test_arbitration;
    test_reset_in_load;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
